// File: rtl/regfile_access_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// regfile_access_pkg
//   Shared types and sizing for the register-file access controller.
//   rf_op_e        : command opcode as carried on cmd_op
//   rf_acc_state_e : controller FSM states
// ----------------------------------------------------------------------------
package regfile_access_pkg;

   localparam int RF_NREGS = 32;
   localparam int RF_AW    = 5;
   localparam int RF_XLEN  = 32;

   typedef enum logic [1:0] {
      RF_READ  = 2'd0,
      RF_WRITE = 2'd1,
      RF_DUMP  = 2'd2,
      RF_CLEAR = 2'd3
   } rf_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HALT_WAIT,
      ST_EXEC,
      ST_CLEAR_WR,
      ST_RESP
   } rf_acc_state_e;

endpackage

// File: rtl/regfile_access_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_access_ctrl
//   Drives the integer register file on behalf of an external command stream
//   (READ / WRITE / DUMP / CLEAR). The core is halted through halt_req /
//   halt_ack before any register-file access; results are returned on a
//   valid/ready response stream that honours backpressure.
//
//   Ports
//     clk, rst_n               : clock, synchronous active-low reset
//     cmd_valid/ready/op/addr/wdata : command stream (accepted only in IDLE)
//     rsp_valid/ready/data/addr/last/err : response stream
//     halt_req / halt_ack      : core pause handshake
//     rf_ra / rf_rd            : register-file read port (combinational data)
//     rf_we / rf_wa / rf_wd    : register-file write port
//     busy                     : high whenever not IDLE
// ----------------------------------------------------------------------------
module regfile_access_ctrl
   import regfile_access_pkg::*;
#(
   parameter int XLEN  = RF_XLEN,
   parameter int NREGS = RF_NREGS,
   parameter int AW    = RF_AW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic [AW-1:0]   cmd_addr,
   input  logic [XLEN-1:0] cmd_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_data,
   output logic [AW-1:0]   rsp_addr,
   output logic            rsp_last,
   output logic            rsp_err,
   output logic            halt_req,
   input  logic            halt_ack,
   output logic [AW-1:0]   rf_ra,
   input  logic [XLEN-1:0] rf_rd,
   output logic            rf_we,
   output logic [AW-1:0]   rf_wa,
   output logic [XLEN-1:0] rf_wd,
   output logic            busy
);

   localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

   rf_acc_state_e   state;
   rf_op_e          op_q;
   logic [AW-1:0]   addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [AW-1:0]   cnt;

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         op_q      <= RF_READ;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt       <= '0;
         halt_req  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_addr  <= '0;
         rsp_last  <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_q     <= rf_op_e'(cmd_op);
                  addr_q   <= cmd_addr;
                  wdata_q  <= cmd_wdata;
                  cnt      <= '0;
                  halt_req <= 1'b1;
                  state    <= ST_HALT_WAIT;
               end
            end
            ST_HALT_WAIT: begin
               if (halt_ack) state <= ST_EXEC;
            end
            ST_EXEC: begin
               // Every op except CLEAR produces its response directly from here.
               state     <= ST_RESP;
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_last  <= 1'b1;
               case (op_q)
                  RF_READ: begin
                     rsp_data <= rf_rd;
                     rsp_addr <= addr_q;
                  end
                  RF_WRITE: begin
                     rsp_data <= wdata_q;
                     rsp_addr <= addr_q;
                     rsp_err  <= (addr_q == '0);  // x0 is read-only
                  end
                  RF_DUMP: begin
                     rsp_data <= (cnt == '0) ? '0 : rf_rd;
                     rsp_addr <= cnt;
                     rsp_last <= (cnt == LAST_REG);
                  end
                  RF_CLEAR: begin
                     cnt       <= AW'(1);  // skip x0
                     rsp_valid <= 1'b0;
                     state     <= ST_CLEAR_WR;
                  end
                  default: state <= ST_RESP;
               endcase
            end
            ST_CLEAR_WR: begin
               if (cnt == LAST_REG) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= '0;
                  rsp_addr  <= '0;
                  rsp_last  <= 1'b1;
                  rsp_err   <= 1'b0;
                  state     <= ST_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  // DUMP keeps the core halted across all of its responses.
                  if (op_q == RF_DUMP && !rsp_last) begin
                     cnt   <= cnt + 1'b1;
                     state <= ST_EXEC;
                  end else begin
                     halt_req <= 1'b0;
                     state    <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Register-file port drive; only active while the core is known halted.
   always_comb begin
      rf_ra = '0;
      rf_we = 1'b0;
      rf_wa = '0;
      rf_wd = '0;
      if (state == ST_EXEC) begin
         if (op_q == RF_DUMP)      rf_ra = cnt;
         else if (op_q == RF_READ) rf_ra = addr_q;
         if (op_q == RF_WRITE && addr_q != '0) begin
            rf_we = 1'b1;
            rf_wa = addr_q;
            rf_wd = wdata_q;
         end
      end else if (state == ST_CLEAR_WR) begin
         rf_we = 1'b1;
         rf_wa = cnt;
      end
   end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
module tb_regfile_access_ctrl;
   import regfile_access_pkg::*;

   localparam int XLEN = 32, NREGS = 32, AW = 5;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cmd_valid, cmd_ready;
   logic [1:0]      cmd_op;
   logic [AW-1:0]   cmd_addr;
   logic [XLEN-1:0] cmd_wdata;
   logic            rsp_valid, rsp_ready;
   logic [XLEN-1:0] rsp_data;
   logic [AW-1:0]   rsp_addr;
   logic            rsp_last, rsp_err;
   logic            halt_req, halt_ack;
   logic [AW-1:0]   rf_ra, rf_wa;
   logic [XLEN-1:0] rf_rd, rf_wd;
   logic            rf_we, busy;

   regfile_access_ctrl #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_addr(rsp_addr), .rsp_last(rsp_last), .rsp_err(rsp_err),
      .halt_req(halt_req), .halt_ack(halt_ack),
      .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_we(rf_we), .rf_wa(rf_wa),
      .rf_wd(rf_wd), .busy(busy)
   );

   always #5 clk = ~clk;

   // Environment register file: plain storage, writes whatever the DUT asks.
   logic [XLEN-1:0] rf_mem   [NREGS];
   logic [XLEN-1:0] load_img [NREGS];
   logic            load_req = 1'b0;
   assign rf_rd = rf_mem[rf_ra];
   always @(posedge clk) begin
      if (load_req) begin
         for (int i = 0; i < NREGS; i++) rf_mem[i] <= load_img[i];
      end else if (rf_we) begin
         rf_mem[rf_wa] <= rf_wd;
      end
   end

   // Reference model: architectural register contents plus expected traffic.
   typedef struct {
      logic [XLEN-1:0] data;
      logic [AW-1:0]   addr;
      logic            last;
      logic            err;
   } rsp_t;
   typedef struct {
      logic [AW-1:0]   wa;
      logic [XLEN-1:0] wd;
   } wr_t;

   logic [XLEN-1:0] ref_mem [NREGS];
   rsp_t exp_q[$];
   wr_t  exp_wq[$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input int mode);  // 0: xi=i*4, 1: random
      for (int i = 0; i < NREGS; i++) begin
         load_img[i] = (i == 0) ? '0 : ((mode == 0) ? XLEN'(i * 4) : $urandom);
         ref_mem[i]  = load_img[i];
      end
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   task automatic model_cmd(input int op, input int a, input logic [XLEN-1:0] w);
      rsp_t r;
      wr_t  wr;
      case (op)
         0: begin
            r.data = (a == 0) ? '0 : ref_mem[a]; r.addr = AW'(a); r.last = 1; r.err = 0;
            exp_q.push_back(r);
         end
         1: begin
            r.data = w; r.addr = AW'(a); r.last = 1; r.err = (a == 0);
            exp_q.push_back(r);
            if (a != 0) begin
               ref_mem[a] = w;
               wr.wa = AW'(a); wr.wd = w;
               exp_wq.push_back(wr);
            end
         end
         2: begin
            for (int i = 0; i < NREGS; i++) begin
               r.data = (i == 0) ? '0 : ref_mem[i]; r.addr = AW'(i);
               r.last = (i == NREGS - 1); r.err = 0;
               exp_q.push_back(r);
            end
         end
         default: begin
            for (int i = 1; i < NREGS; i++) begin
               ref_mem[i] = '0;
               wr.wa = AW'(i); wr.wd = '0;
               exp_wq.push_back(wr);
            end
            r.data = '0; r.addr = '0; r.last = 1; r.err = 0;
            exp_q.push_back(r);
         end
      endcase
   endtask

   // rmode: 0 always ready, 1 pattern 1,0,0,1..., 2 random.
   // abort_after>0: apply a one-cycle reset once that many responses are taken.
   task automatic run_cmd(input int op, input int a, input logic [XLEN-1:0] w,
                          input int ack_dly, input int rmode, input int abort_after);
      int   k, nrsp, nexp, nwexp, first_v, nw, wfirst, wlast, vi;
      logic prev_stall;
      rsp_t prev_r, e;
      wr_t  ew;
      model_cmd(op, a, w);
      nexp  = exp_q.size();
      nwexp = exp_wq.size();
      k = 0;
      while (!cmd_ready && k < 100) begin tick(); k++; end
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1; cmd_op = 2'(op); cmd_addr = AW'(a); cmd_wdata = w;
      tick();
      cmd_valid = 0; cmd_addr = AW'($urandom); cmd_wdata = $urandom;  // must be latched
      k = 0; nrsp = 0; first_v = -1; nw = 0; wfirst = 0; wlast = 0; vi = 0;
      prev_stall = 0;
      while (exp_q.size() > 0 && k < 3000) begin
         if (abort_after > 0 && nrsp == abort_after) break;
         k++;
         halt_ack = (k > ack_dly);
         case (rmode)
            0:       rsp_ready = 1;
            1:       rsp_ready = ((vi % 3) == 0);
            default: rsp_ready = $urandom_range(0, 1);
         endcase
         chk("halt_req_held", halt_req, 1);
         if (k <= ack_dly) begin
            chk("halt_busy", busy, 1);
            chk("halt_cmd_ready", cmd_ready, 0);
            chk("halt_rsp_valid", rsp_valid, 0);
            chk("halt_rf_ra", rf_ra, 0);
            chk("halt_rf_we", rf_we, 0);
         end
         if (rf_we) begin
            if (nw == 0) wfirst = k;
            wlast = k;
            nw++;
            if (exp_wq.size() == 0) chk("unexpected_we", rf_we, 0);
            else begin
               ew = exp_wq.pop_front();
               chk("rf_wa", rf_wa, ew.wa);
               chk("rf_wd", rf_wd, ew.wd);
            end
         end
         if (rsp_valid) begin
            vi++;
            if (first_v < 0) first_v = k;
            if (prev_stall) begin
               chk("stall_data", rsp_data, prev_r.data);
               chk("stall_addr", rsp_addr, prev_r.addr);
               chk("stall_last", rsp_last, prev_r.last);
            end
            prev_r.data = rsp_data; prev_r.addr = rsp_addr;
            prev_r.last = rsp_last; prev_r.err = rsp_err;
            prev_stall = !rsp_ready;
            if (rsp_ready) begin
               e = exp_q.pop_front();
               chk("rsp_data", rsp_data, e.data);
               chk("rsp_addr", rsp_addr, e.addr);
               chk("rsp_last", rsp_last, e.last);
               chk("rsp_err", rsp_err, e.err);
               nrsp++;
            end
         end else prev_stall = 0;
         tick();
      end
      if (abort_after > 0) begin
         rst_n = 0; rsp_ready = 0;
         tick();
         rst_n = 1;
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_halt_req", halt_req, 0);
         chk("rst_cmd_ready", cmd_ready, 1);
         chk("rst_busy", busy, 0);
         chk("rst_rf_we", rf_we, 0);
         exp_q.delete();
         exp_wq.delete();
      end else begin
         chk("rsp_count", nrsp, nexp);
         chk("wr_count", nw, nwexp);
         chk("post_cmd_ready", cmd_ready, 1);
         chk("post_halt_req", halt_req, 0);
         chk("post_busy", busy, 0);
         chk("post_rsp_valid", rsp_valid, 0);
         if (op <= 1) chk("latency", first_v, 3 + ack_dly);
         if (op == 3) chk("clear_consec", wlast - wfirst, NREGS - 2);
         exp_q.delete();
         exp_wq.delete();
      end
   endtask

   initial begin
      rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_wdata = 0;
      rsp_ready = 0; halt_ack = 0;
      tick(); tick();
      rst_n = 1;
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_data", rsp_data, 0);
      chk("reset_rsp_addr", rsp_addr, 0);
      chk("reset_rsp_last", rsp_last, 0);
      chk("reset_rsp_err", rsp_err, 0);
      chk("reset_halt_req", halt_req, 0);
      chk("reset_rf", {rf_we, rf_ra, rf_wa, rf_wd}, 0);
      chk("reset_busy", busy, 0);
      chk("reset_cmd_ready", cmd_ready, 1);

      // Single-register read / write, including x0 rules.
      preload(1);
      load_img[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
      load_req = 1; tick(); load_req = 0;
      run_cmd(0, 5, 0, 0, 0, 0);
      run_cmd(1, 10, 32'h12345678, 0, 0, 0);
      run_cmd(0, 10, 0, 0, 0, 0);
      run_cmd(1, 0, 32'hFFFFFFFF, 0, 0, 0);
      run_cmd(0, 0, 0, 0, 0, 0);

      // Long halt acknowledge.
      run_cmd(0, 7, 0, 20, 0, 0);

      // Dump with backpressure pattern.
      preload(0);
      run_cmd(2, 0, 0, 0, 1, 0);

      // Clear then dump.
      preload(1);
      run_cmd(3, 0, 0, 1, 0, 0);
      run_cmd(2, 0, 0, 0, 2, 0);

      // Reset in the middle of a dump, then a normal read.
      preload(0);
      run_cmd(2, 0, 0, 0, 0, 12);
      run_cmd(0, 3, 0, 0, 0, 0);

      // Random command mix.
      for (int n = 0; n < 30; n++) begin
         run_cmd($urandom_range(0, 3), $urandom_range(0, NREGS - 1), $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 2), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
